// File: rtl/leitor_cedulas_if.sv
// Bundle of the raw note/button inputs and the display-side outputs of leitor_cedulas.
// master drives the raw inputs; slave is the reader block itself.
interface leitor_cedulas_if;
  logic [2:0] chaves;
  logic       botao_inserir;
  logic       botao_cancelar;
  logic [2:0] chaves_cedulas;
  logic       V_sense;
  logic       sinal_cancel;
  logic [2:0] select;
  logic [6:0] valor_reais;
  logic       cedula_valida;

  modport master (
    output chaves, botao_inserir, botao_cancelar,
    input  chaves_cedulas, V_sense, sinal_cancel, select, valor_reais, cedula_valida
  );

  modport slave (
    input  chaves, botao_inserir, botao_cancelar,
    output chaves_cedulas, V_sense, sinal_cancel, select, valor_reais, cedula_valida
  );
endinterface

// File: rtl/leitor_cedulas.sv
// Note reader front end: synchronize and debounce buttons, latch an accepted note code,
// hold it (or a cancel) for a fixed time, and run the free 0..6 digit-scan counter.
module leitor_cedulas #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned HOLD_CYCLES     = 64
) (
  input logic              clk,
  input logic              reset,
  leitor_cedulas_if.slave  bus
);
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HdW = $clog2(HOLD_CYCLES);
  localparam int unsigned PsW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StExibe, StCancela} state_e;

  // Button index 0 = insert, 1 = cancel.
  logic [2:0]           chaves_s1_q, chaves_s2_q;
  logic [1:0]           btn_s1_q, btn_s2_q;
  logic [1:0]           deb_q, deb_prev_q;
  logic [1:0][DbW-1:0]  deb_cnt_q;
  logic                 ins_ev, can_ev;

  state_e               state_q, state_d;
  logic [HdW-1:0]       hold_q, hold_d;
  logic [2:0]           code_q, code_d;
  logic [6:0]           valor_q;
  logic                 pulse_q, accept;
  logic                 hold_done;

  logic [PsW-1:0]       presc_q;
  logic [2:0]           select_q;

  function automatic logic [6:0] decode_valor(input logic [2:0] c);
    case (c)
      3'd1:    decode_valor = 7'd1;
      3'd2:    decode_valor = 7'd2;
      3'd3:    decode_valor = 7'd5;
      3'd4:    decode_valor = 7'd10;
      3'd5:    decode_valor = 7'd20;
      3'd6:    decode_valor = 7'd50;
      3'd7:    decode_valor = 7'd100;
      default: decode_valor = 7'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      chaves_s1_q <= '0;
      chaves_s2_q <= '0;
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      deb_cnt_q   <= '0;
    end else begin
      chaves_s1_q <= bus.chaves;
      chaves_s2_q <= chaves_s1_q;
      btn_s1_q    <= {bus.botao_cancelar, bus.botao_inserir};
      btn_s2_q    <= btn_s1_q;
      deb_prev_q  <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (btn_s2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DbW'(DEBOUNCE_CYCLES)) begin
          deb_q[i]     <= ~deb_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign ins_ev    = deb_q[0] & ~deb_prev_q[0];
  assign can_ev    = deb_q[1] & ~deb_prev_q[1];
  assign hold_done = (hold_q == HdW'(HOLD_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Cancel has priority over a simultaneous insert.
        if (can_ev) begin
          state_d = StCancela;
        end else if (ins_ev && (chaves_s2_q != 3'b000)) begin
          state_d = StExibe;
          code_d  = chaves_s2_q;
          accept  = 1'b1;
        end
      end
      StExibe: begin
        if (can_ev) begin
          state_d = StCancela;
          code_d  = 3'b000;
        end else if (hold_done) begin
          state_d = StIdle;
          code_d  = 3'b000;
        end
      end
      StCancela: begin
        if (hold_done) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        code_d  = 3'b000;
      end
    endcase
    hold_d = ((state_d != state_q) || (state_q == StIdle)) ? '0 : hold_q + HdW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      code_q  <= '0;
      valor_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      code_q  <= code_d;
      valor_q <= decode_valor(code_d);
      pulse_q <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      select_q <= '0;
    end else if (presc_q == PsW'(SCAN_DIV - 1)) begin
      presc_q  <= '0;
      select_q <= (select_q == 3'd6) ? 3'd0 : select_q + 3'd1;
    end else begin
      presc_q  <= presc_q + PsW'(1);
    end
  end

  assign bus.chaves_cedulas = code_q;
  assign bus.valor_reais    = valor_q;
  assign bus.cedula_valida  = pulse_q;
  assign bus.V_sense        = (state_q != StExibe);
  assign bus.sinal_cancel   = (state_q == StCancela);
  assign bus.select         = select_q;
endmodule

// File: tb/tb_leitor_cedulas.sv
// Directed bench for leitor_cedulas with default parameters (debounce 16, scan 4, hold 64).
module tb_leitor_cedulas;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pulses   = 0;
  int   t;
  int   snap;

  leitor_cedulas_if bus ();

  leitor_cedulas #(
    .DEBOUNCE_CYCLES(16),
    .SCAN_DIV(4),
    .HOLD_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.cedula_valida === 1'b1) pulses++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until edge e (counted from the scenario start, edge 0 first) has passed.
  task automatic step_to(input int e);
    while (t < e) begin
      tick();
      t++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_vsense"}, 32'(bus.V_sense), 1);
    check_eq({tag, "_cancel"}, 32'(bus.sinal_cancel), 0);
    check_eq({tag, "_code"}, 32'(bus.chaves_cedulas), 0);
    check_eq({tag, "_valor"}, 32'(bus.valor_reais), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.chaves = 3'b000;
    bus.botao_inserir = 1'b0;
    bus.botao_cancelar = 1'b0;
    idle(3);
    check_idle("rst");
    check_eq("rst_select", 32'(bus.select), 0);
    check_eq("rst_pulse", 32'(bus.cedula_valida), 0);

    // Scan: each select value for 4 cycles, wrapping 6 -> 0.
    reset = 1'b0;
    for (int j = 0; j < 56; j++) begin
      check_eq($sformatf("scan_%0d", j), 32'(bus.select), 32'((j / 4) % 7));
      tick();
    end
    check_idle("scan_idle");

    // Accept R$50.
    bus.chaves = 3'b110;
    bus.botao_inserir = 1'b1;
    t = -1;
    step_to(18);
    check_eq("r50_pre_vsense", 32'(bus.V_sense), 1);
    check_eq("r50_pre_pulse", 32'(bus.cedula_valida), 0);
    step_to(19);
    check_eq("r50_vsense", 32'(bus.V_sense), 0);
    check_eq("r50_code", 32'(bus.chaves_cedulas), 6);
    check_eq("r50_valor", 32'(bus.valor_reais), 50);
    check_eq("r50_pulse", 32'(bus.cedula_valida), 1);
    step_to(20);
    check_eq("r50_pulse_off", 32'(bus.cedula_valida), 0);
    check_eq("r50_code_hold", 32'(bus.chaves_cedulas), 6);
    step_to(29);
    bus.botao_inserir = 1'b0;
    step_to(82);
    check_eq("r50_last_vsense", 32'(bus.V_sense), 0);
    check_eq("r50_last_valor", 32'(bus.valor_reais), 50);
    step_to(83);
    check_idle("r50_end");
    idle(30);

    // Bounce: 5 high / 3 low never reaches 16 stable cycles.
    snap = pulses;
    bus.chaves = 3'b011;
    for (int k = 0; k < 5; k++) begin
      bus.botao_inserir = 1'b1;
      idle(5);
      bus.botao_inserir = 1'b0;
      idle(3);
    end
    idle(30);
    check_idle("bounce");
    check_eq("bounce_pulses", 32'(pulses), 32'(snap));

    // Insert with code 000 is rejected.
    bus.chaves = 3'b000;
    bus.botao_inserir = 1'b1;
    t = -1;
    step_to(19);
    check_idle("zero");
    check_eq("zero_pulse", 32'(bus.cedula_valida), 0);
    step_to(29);
    bus.botao_inserir = 1'b0;
    idle(30);
    check_eq("zero_pulses", 32'(pulses), 32'(snap));

    // Accept R$100, cancel 20 cycles into EXIBE, insert ignored during CANCELA.
    bus.chaves = 3'b111;
    bus.botao_inserir = 1'b1;
    t = -1;
    step_to(19);
    check_eq("r100_code", 32'(bus.chaves_cedulas), 7);
    check_eq("r100_valor", 32'(bus.valor_reais), 100);
    check_eq("r100_vsense", 32'(bus.V_sense), 0);
    step_to(20);
    snap = pulses;
    step_to(25);
    bus.botao_inserir = 1'b0;
    step_to(38);
    bus.botao_cancelar = 1'b1;
    step_to(57);
    check_eq("canc_pre_code", 32'(bus.chaves_cedulas), 7);
    check_eq("canc_pre_sig", 32'(bus.sinal_cancel), 0);
    step_to(58);
    check_eq("canc_sig", 32'(bus.sinal_cancel), 1);
    check_eq("canc_vsense", 32'(bus.V_sense), 1);
    check_eq("canc_code", 32'(bus.chaves_cedulas), 0);
    check_eq("canc_valor", 32'(bus.valor_reais), 0);
    step_to(60);
    bus.chaves = 3'b010;
    bus.botao_inserir = 1'b1;
    step_to(70);
    bus.botao_cancelar = 1'b0;
    step_to(90);
    check_eq("canc_ins_sig", 32'(bus.sinal_cancel), 1);
    check_eq("canc_ins_code", 32'(bus.chaves_cedulas), 0);
    step_to(121);
    check_eq("canc_last_sig", 32'(bus.sinal_cancel), 1);
    step_to(122);
    check_idle("canc_end");
    check_eq("canc_pulses", 32'(pulses), 32'(snap));
    bus.botao_inserir = 1'b0;
    idle(30);

    // Simultaneous insert and cancel: cancel wins, no pulse.
    snap = pulses;
    bus.chaves = 3'b001;
    bus.botao_inserir = 1'b1;
    bus.botao_cancelar = 1'b1;
    t = -1;
    step_to(19);
    check_eq("sim_sig", 32'(bus.sinal_cancel), 1);
    check_eq("sim_code", 32'(bus.chaves_cedulas), 0);
    check_eq("sim_pulse", 32'(bus.cedula_valida), 0);
    step_to(25);
    bus.botao_inserir = 1'b0;
    bus.botao_cancelar = 1'b0;
    step_to(84);
    check_idle("sim_end");
    check_eq("sim_pulses", 32'(pulses), 32'(snap));
    idle(30);

    // Reset during EXIBE; held button re-debounces from scratch.
    bus.chaves = 3'b100;
    bus.botao_inserir = 1'b1;
    t = -1;
    step_to(19);
    check_eq("mr_code", 32'(bus.chaves_cedulas), 4);
    check_eq("mr_valor", 32'(bus.valor_reais), 10);
    step_to(25);
    reset = 1'b1;
    step_to(26);
    check_idle("mr_rst");
    check_eq("mr_select", 32'(bus.select), 0);
    check_eq("mr_pulse", 32'(bus.cedula_valida), 0);
    reset = 1'b0;
    step_to(45);
    check_eq("mr_pre_vsense", 32'(bus.V_sense), 1);
    step_to(46);
    check_eq("mr_re_vsense", 32'(bus.V_sense), 0);
    check_eq("mr_re_pulse", 32'(bus.cedula_valida), 1);
    check_eq("mr_re_code", 32'(bus.chaves_cedulas), 4);
    bus.botao_inserir = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/leitor_cedulas.md
# leitor_cedulas

Front end of the note-payment path. Synchronizes and debounces the three note-selection switches and the insert/cancel buttons, then latches an accepted note code. It produces the note code, presence flag, cancel flag and free-running 0..6 digit-scan counter consumed by the seven-segment value display. It also reports the accepted note's value in reais and pulses once per accepted note.

## Interface

- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a synchronized button level is accepted (≥2).
- SCAN_DIV, 4: clock cycles per scan step of `select` (≥1).
- HOLD_CYCLES, 64: cycles an accepted note or cancel stays displayed (≥2).

- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high; clears every register.
- chaves  in  3  raw note-selection switches, asynchronous.
- botao_inserir  in  1  raw insert button, active-high, bouncy.
- botao_cancelar  in  1  raw cancel button, active-high, bouncy.
- chaves_cedulas  out  3  latched note code: 000 none, 001 R$1, 010 R$2, 011 R$5, 100 R$10, 101 R$20, 110 R$50, 111 R$100.
- V_sense  out  1  0 = note being shown, 1 = no note.
- sinal_cancel  out  1  1 while a cancel is being shown.
- select  out  3  digit-scan counter, 0..6.
- valor_reais  out  7  binary value of latched code (0,1,2,5,10,20,50,100).
- cedula_valida  out  1  one-cycle pulse on note acceptance.

## Operation

- **Input path:**
  - All three raw inputs pass through 2-flop synchronizers.
  - Each button has a debounce counter. It increments while the synchronized level differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - A press event is the 0→1 transition of the debounced level. Releases generate no event.
  - The switch code is taken from the synchronized `chaves` value in the press-event cycle.
- **FSM states:** IDLE, EXIBE, CANCELA.
- **IDLE:**
  - Outputs: V_sense=1, sinal_cancel=0, chaves_cedulas=000, valor_reais=0.
  - Cancel event → CANCELA.
  - Insert event with code ≠000 → EXIBE. Latch the code, set valor_reais, pulse cedula_valida.
  - Insert event with code 000 → stays IDLE, no pulse.
- **EXIBE:**
  - Outputs: V_sense=0, latched code held.
  - Insert events are ignored. The code does not change.
  - Cancel event → CANCELA.
  - Hold counter reaching HOLD_CYCLES → IDLE.
- **CANCELA:**
  - Outputs: sinal_cancel=1, V_sense=1, chaves_cedulas=000, valor_reais=0.
  - Both button events are ignored.
  - Hold counter reaching HOLD_CYCLES → IDLE.
- **Hold counter:** clears on every state entry and counts cycles spent in the state.
- **Simultaneous insert and cancel events in IDLE:** cancel wins. No latch, no pulse.
- **Scan counter:**
  - The prescaler counts 0..SCAN_DIV-1. On wrap, `select` increments and goes 6→0. The value 7 never appears.
  - Scanning is free-running and independent of the FSM.
- **valor_reais:** a registered decode of chaves_cedulas, updated in the same cycle as the code.

## Timing

- **Reset values:**
  - Outputs: chaves_cedulas=000, V_sense=1, sinal_cancel=0, select=0, valor_reais=0, cedula_valida=0.
  - Internal: FSM IDLE, debounced levels 0, all counters 0.
- **Reset mid-operation:** any state returns to IDLE on the next edge. A button still held after reset must produce a fresh press event once debounced; the debounced level restarts at 0.
- **Press latency:** raw button rising at edge 0 and held steady → press event in cycle DEBOUNCE_CYCLES+2. Outputs and cedula_valida update at edge DEBOUNCE_CYCLES+3.
- **Bounce rejection:** any glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- **Hold duration:** EXIBE or CANCELA lasts exactly HOLD_CYCLES cycles. V_sense returns to 1 (or sinal_cancel to 0) on the following edge.
- **cedula_valida:** exactly one cycle high, coincident with the first cycle of V_sense=0.
- **Scan rate:** `select` holds each value exactly SCAN_DIV cycles. The full sequence period is 7·SCAN_DIV cycles.

## Test plan

- **Reset and scan:** hold reset 3 cycles, release, run 7·SCAN_DIV·2 cycles → select follows 0..6,0..6, each value for 4 cycles. Reset outputs as listed throughout.
- **Accept R$50:** chaves=110, press insert 30 cycles → event at cycle 18. At edge 19: V_sense=0, chaves_cedulas=110, valor_reais=50, one-cycle cedula_valida. After 64 cycles: V_sense=1, code=000.
- **Bounce and invalid code:**
  - Toggle insert in pulses of 5 cycles high / 3 low for 40 cycles → no event.
  - Press insert for 30 cycles with chaves=000 → stays IDLE, no pulse.
- **Cancel during note:** accept R$100 (code 111). Press cancel 20 cycles into EXIBE → sinal_cancel=1, code=000, valor_reais=0 for 64 cycles. Insert presses during that window are ignored.
- **Simultaneous and mid-reset:**
  - Insert and cancel asserted on the same edge with chaves=001 → CANCELA, no cedula_valida.
  - Pulse reset during EXIBE → all reset values on the next edge.
